// File: rtl/mem_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_bridge
// Description : Converts 32-bit CPU load/store requests into byte-serial
//               cycles on an 8-bit asynchronous SRAM. Each byte takes one
//               SETUP cycle (chip enable, address, write data) followed by
//               WAIT_CYCLES+1 ACCESS cycles with OE_n or WE_n asserted.
//               Load bytes are assembled little-endian, sign/zero extended
//               and presented on rdata together with a one-cycle done pulse.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W       SRAM byte address width; upper CPU address bits are ignored
//   WAIT_CYCLES  extra cycles OE_n/WE_n are held low per byte (0..15)
// Configuration macro
//   MEM_BRIDGE_MISALIGN_EN  when defined, misaligned halfword/word accesses
//                           run byte-serially; when undefined they are
//                           rejected with a fault pulse.
// Ports
//   clk          in   system clock, all state on posedge
//   reset_n      in   asynchronous active-low reset
//   addr         in   byte address, sampled at accept
//   wdata        in   store data, sampled at accept
//   req_read     in   load request
//   req_write    in   store request
//   req_size     in   {lb,lbu,lh,lhu} one-hot, 0 = word
//   ready        out  request can be accepted this cycle
//   done         out  one-cycle pulse, access complete
//   fault        out  one-cycle pulse, request rejected
//   rdata        out  assembled load data, held until next load completes
//   bus_oe       out  rdata should drive the CPU bus (done of a load)
//   sram_addr    out  SRAM byte address
//   sram_wdata   out  SRAM write byte
//   sram_rdata   in   SRAM read byte
//   sram_ce_n    out  SRAM chip enable, active-low
//   sram_oe_n    out  SRAM output enable, active-low
//   sram_we_n    out  SRAM write enable, active-low
// ============================================================================
module mem_byte_bridge #(
  parameter int ADDR_W      = 19,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [3:0]        req_size,
  output logic              ready,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic              bus_oe,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched request
  logic              r_is_read;
  logic [3:0]        r_size;
  logic [1:0]        r_last_idx;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_wdata_rest;   // store bytes not yet presented to the SRAM
  logic [3:0]        r_wait_cnt;
  logic [31:0]       r_buf;          // load byte lanes collected so far

  // Registered outputs
  logic              r_fault;
  logic [31:0]       r_rdata;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [7:0]        r_sram_wdata;

  // Request decode
  logic              w_ready;
  logic              w_one_req;
  logic              w_both_req;
  logic              w_size_multi;
  logic              w_is_half;
  logic              w_is_word;
  logic              w_misalign;
  logic              w_accept;
  logic              w_reject;
  logic [1:0]        w_last_nxt;

  // Byte progress
  logic              w_byte_done;
  logic              w_last_byte;
  logic [31:0]       w_lanes;
  logic [31:0]       w_ext;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign w_ready      = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_one_req    = req_read ^ req_write;
  assign w_both_req   = req_read & req_write;
  // x & (x-1) clears the lowest set bit; anything left means two or more bits
  assign w_size_multi = |(req_size & (req_size - 4'd1));
  assign w_is_half    = req_size[1] | req_size[0];
  assign w_is_word    = (req_size == 4'd0);

`ifdef MEM_BRIDGE_MISALIGN_EN
  assign w_misalign = 1'b0;
`else
  assign w_misalign = (w_is_half & addr[0]) | (w_is_word & (addr[1:0] != 2'b00));
`endif

  assign w_accept = w_ready & w_one_req & ~w_size_multi & ~w_misalign;
  assign w_reject = w_ready & (w_both_req | (w_one_req & (w_size_multi | w_misalign)));

  // Index of the final byte: 0 for byte, 1 for halfword, 3 for word
  always_comb begin
    w_last_nxt = 2'd0;
    if (w_is_word) begin
      w_last_nxt = 2'd3;
    end else if (w_is_half) begin
      w_last_nxt = 2'd1;
    end
  end

  // Only the low ADDR_W address bits reach the SRAM
  generate
    if (ADDR_W < 32) begin : g_unused_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = &{1'b0, addr[31:ADDR_W]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  assign w_byte_done = (r_state == S_ACCESS) && (r_wait_cnt == 4'd0);
  assign w_last_byte = w_byte_done && (r_byte_idx == r_last_idx);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_byte_done) begin
          w_state_nxt = w_last_byte ? S_DONE : S_SETUP;
        end
      end
      S_DONE: begin
        // A request taken in DONE goes straight to SETUP with no idle gap
        w_state_nxt = w_accept ? S_SETUP : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Load assembly: merge the byte arriving now into its lane, then extend
  // --------------------------------------------------------------------------
  always_comb begin
    w_lanes = r_buf;
    w_lanes[{r_byte_idx, 3'b000} +: 8] = sram_rdata;
    if (r_size[3]) begin
      w_ext = {{24{w_lanes[7]}}, w_lanes[7:0]};
    end else if (r_size[2]) begin
      w_ext = {24'h000000, w_lanes[7:0]};
    end else if (r_size[1]) begin
      w_ext = {{16{w_lanes[15]}}, w_lanes[15:0]};
    end else if (r_size[0]) begin
      w_ext = {16'h0000, w_lanes[15:0]};
    end else begin
      w_ext = w_lanes;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and SRAM strobes. Strobes are registered from the next state so
  // the async SRAM sees glitch-free control lines; WE_n/OE_n can only fall
  // on entry to ACCESS, which always follows a SETUP cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_is_read    <= 1'b0;
      r_size       <= 4'd0;
      r_last_idx   <= 2'd0;
      r_byte_idx   <= 2'd0;
      r_wdata_rest <= 24'd0;
      r_wait_cnt   <= 4'd0;
      r_buf        <= 32'd0;
      r_fault      <= 1'b0;
      r_rdata      <= 32'd0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_sram_addr  <= '0;
      r_sram_wdata <= 8'd0;
    end else begin
      r_fault <= w_reject;
      r_ce_n  <= !((w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS));
      r_oe_n  <= !((w_state_nxt == S_ACCESS) && r_is_read);
      r_we_n  <= !((w_state_nxt == S_ACCESS) && !r_is_read);

      if (w_accept) begin
        r_is_read    <= req_read;
        r_size       <= req_size;
        r_last_idx   <= w_last_nxt;
        r_byte_idx   <= 2'd0;
        r_sram_addr  <= addr[ADDR_W-1:0];
        r_sram_wdata <= wdata[7:0];
        r_wdata_rest <= wdata[31:8];
      end else if (w_byte_done && !w_last_byte) begin
        // Advance to the next byte; the address wraps modulo 2^ADDR_W
        r_byte_idx   <= r_byte_idx + 2'd1;
        r_sram_addr  <= r_sram_addr + ADDR_W'(1);
        r_sram_wdata <= r_wdata_rest[7:0];
        r_wdata_rest <= {8'h00, r_wdata_rest[23:8]};
      end

      if (r_state == S_SETUP) begin
        r_wait_cnt <= C_WAIT_LOAD;
      end else if ((r_state == S_ACCESS) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end

      if (w_byte_done && r_is_read) begin
        r_buf <= w_lanes;
      end

      // rdata changes only as DONE is entered for a load
      if (w_last_byte && r_is_read) begin
        r_rdata <= w_ext;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ready      = w_ready;
  assign done       = (r_state == S_DONE);
  assign fault      = r_fault;
  assign rdata      = r_rdata;
  assign bus_oe     = (r_state == S_DONE) & r_is_read;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_byte_bridge
// Description : Self-checking bench for mem_byte_bridge with a behavioural
//               8-bit SRAM, a vector table and directed multi-cycle sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_byte_bridge;

  localparam int ADDR_W      = 19;
  localparam int WAIT_CYCLES = 1;
  localparam int BYTE_CYC    = WAIT_CYCLES + 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              req_read;
  logic              req_write;
  logic [3:0]        req_size;
  logic              ready;
  logic              done;
  logic              fault;
  logic [31:0]       rdata;
  logic              bus_oe;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_wdata;
  logic [7:0]        sram_rdata;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  always #5 clk = ~clk;

  mem_byte_bridge #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .addr       (addr),
    .wdata      (wdata),
    .req_read   (req_read),
    .req_write  (req_write),
    .req_size   (req_size),
    .ready      (ready),
    .done       (done),
    .fault      (fault),
    .rdata      (rdata),
    .bus_oe     (bus_oe),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n)
  );

  // --------------------------------------------------------------------------
  // SRAM model (preload port shares the single writer process)
  // --------------------------------------------------------------------------
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [7:0]        pl_data;

  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'h00;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr] <= sram_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Bus monitor: chip-enable cycle count and strobe-rule violations
  // --------------------------------------------------------------------------
  int                ce_cycles = 0;
  int                viol = 0;
  logic              prev_ce_n = 1'b1;
  logic              prev_oe_n = 1'b1;
  logic              prev_we_n = 1'b1;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [7:0]        prev_wd = 8'h00;

  always @(negedge clk) begin
    if (reset_n) begin
      if (!sram_ce_n) ce_cycles++;
      if (!sram_oe_n && !sram_we_n) viol++;
      if ((!sram_oe_n || !sram_we_n) && sram_ce_n) viol++;
      // a strobe may only fall after a cycle with chip enable already low
      if (((!sram_oe_n && prev_oe_n) || (!sram_we_n && prev_we_n)) && prev_ce_n) viol++;
      if ((!sram_we_n && !prev_we_n) && ((sram_addr != prev_addr) || (sram_wdata != prev_wd))) viol++;
      if ((!sram_oe_n && !prev_oe_n) && (sram_addr != prev_addr)) viol++;
    end
    prev_ce_n = sram_ce_n;
    prev_oe_n = sram_oe_n;
    prev_we_n = sram_we_n;
    prev_addr = sram_addr;
    prev_wd   = sram_wdata;
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_fault;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_boe;
    int          exp_ce;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  function automatic vec_t mk_ok(input logic rd, input logic [3:0] sz, input logic [31:0] a,
                                 input logic [31:0] wd, input int n, input logic [31:0] exp_rd);
    vec_t v;
    v.rd = rd; v.wr = !rd; v.size = sz; v.addr = a; v.wdata = wd;
    v.exp_fault = 1'b0; v.exp_lat = n * BYTE_CYC + 1; v.exp_rdata = exp_rd;
    v.exp_boe = rd; v.exp_ce = n * BYTE_CYC;
    return v;
  endfunction

  function automatic vec_t mk_flt(input logic rd, input logic wr, input logic [3:0] sz,
                                  input logic [31:0] a, input logic [31:0] exp_rd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = sz; v.addr = a; v.wdata = 32'h0;
    v.exp_fault = 1'b1; v.exp_lat = 1; v.exp_rdata = exp_rd;
    v.exp_boe = 1'b0; v.exp_ce = 0;
    return v;
  endfunction

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic wait_ready(input int idx);
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", idx, {31'h0, ready}, 32'd1);
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    int          lat;
    int          ce0;
    logic        got_f;
    logic [31:0] rd_v;
    logic        boe_v;
    v = vecs[i];
    @(negedge clk);
    wait_ready(i);
    ce0 = ce_cycles;
    req_read = v.rd; req_write = v.wr; req_size = v.size; addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    #1 req_read = 1'b0; req_write = 1'b0;
    lat = -1; got_f = 1'b0; rd_v = rdata; boe_v = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done || fault) begin
        lat = k; got_f = fault; rd_v = rdata; boe_v = bus_oe;
        break;
      end
    end
    chk("latency",   i, lat,               v.exp_lat);
    chk("fault",     i, {31'h0, got_f},    {31'h0, v.exp_fault});
    chk("rdata",     i, rd_v,              v.exp_rdata);
    chk("bus_oe",    i, {31'h0, boe_v},    {31'h0, v.exp_boe});
    chk("ce_cycles", i, ce_cycles - ce0,   v.exp_ce);
    @(negedge clk);
    chk("one_pulse", i, {30'h0, done, fault}, 32'd0);
  endtask

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int   lat;
    int   n;
    logic seen_done;

    reset_n = 1'b0; addr = 32'h0; wdata = 32'h0;
    req_read = 1'b0; req_write = 1'b0; req_size = 4'h0;
    pl_en = 1'b0; pl_addr = '0; pl_data = 8'h00;

    // Vector table: expected rdata for stores/faults is the previous load value
    vecs[0]  = mk_ok (1'b1, 4'h0, 32'h0000_0100, 32'h0, 4, 32'hDEADBEEF);  // lw
    vecs[1]  = mk_ok (1'b1, 4'h8, 32'h0000_0020, 32'h0, 1, 32'hFFFFFF80);  // lb
    vecs[2]  = mk_ok (1'b1, 4'h4, 32'h0000_0020, 32'h0, 1, 32'h00000080);  // lbu
    vecs[3]  = mk_ok (1'b1, 4'h2, 32'h0000_0020, 32'h0, 2, 32'hFFFFFF80);  // lh
    vecs[4]  = mk_ok (1'b1, 4'h1, 32'h0000_0030, 32'h0, 2, 32'h0000817F);  // lhu
    vecs[5]  = mk_ok (1'b1, 4'h2, 32'h0000_0030, 32'h0, 2, 32'hFFFF817F);  // lh
    vecs[6]  = mk_ok (1'b1, 4'h0, 32'hABC0_0100, 32'h0, 4, 32'hDEADBEEF);  // upper addr ignored
    vecs[7]  = mk_flt(1'b1, 1'b1, 4'h0, 32'h0000_0100, 32'hDEADBEEF);      // read & write
    vecs[8]  = mk_flt(1'b1, 1'b0, 4'hC, 32'h0000_0020, 32'hDEADBEEF);      // two size bits
    vecs[9]  = mk_ok (1'b0, 4'h2, 32'h0000_0040, 32'h1234ABCD, 2, 32'hDEADBEEF);  // sh
    vecs[10] = mk_ok (1'b0, 4'h8, 32'h0000_0050, 32'h000000E7, 1, 32'hDEADBEEF);  // sb
    vecs[11] = mk_ok (1'b0, 4'h0, 32'h0000_0060, 32'hCAFEF00D, 4, 32'hDEADBEEF);  // sw
    vecs[12] = mk_ok (1'b1, 4'h0, 32'h0000_0060, 32'h0, 4, 32'hCAFEF00D);  // lw after sw
    vecs[13] = mk_ok (1'b1, 4'h8, 32'h0000_0021, 32'h0, 1, 32'hFFFFFFFF);  // lb
`ifdef MEM_BRIDGE_MISALIGN_EN
    vecs[14] = mk_ok (1'b1, 4'h0, 32'h0000_0102, 32'h0, 4, 32'h6655DEAD);
    vecs[15] = mk_ok (1'b1, 4'h2, 32'h0000_0021, 32'h0, 2, 32'h000012FF);
    vecs[16] = mk_ok (1'b1, 4'h0, 32'h0007_FFFF, 32'h0, 4, 32'h44332211);  // wraps to 0
`else
    vecs[14] = mk_flt(1'b1, 1'b0, 4'h0, 32'h0000_0102, 32'hFFFFFFFF);
    vecs[15] = mk_flt(1'b1, 1'b0, 4'h2, 32'h0000_0021, 32'hFFFFFFFF);
    vecs[16] = mk_flt(1'b1, 1'b0, 4'h0, 32'h0007_FFFF, 32'hFFFFFFFF);
`endif

    preload(19'h00100, 8'hEF); preload(19'h00101, 8'hBE);
    preload(19'h00102, 8'hAD); preload(19'h00103, 8'hDE);
    preload(19'h00104, 8'h55); preload(19'h00105, 8'h66);
    preload(19'h00020, 8'h80); preload(19'h00021, 8'hFF); preload(19'h00022, 8'h12);
    preload(19'h00030, 8'h7F); preload(19'h00031, 8'h81);
    preload(19'h00042, 8'h5A); preload(19'h00051, 8'h3C);
    preload(19'h7FFFF, 8'h11); preload(19'h00000, 8'h22);
    preload(19'h00001, 8'h33); preload(19'h00002, 8'h44);

    // Reset state
    @(negedge clk);
    chk("rst_ready",  0, {31'h0, ready},     32'd1);
    chk("rst_done",   0, {31'h0, done},      32'd0);
    chk("rst_fault",  0, {31'h0, fault},     32'd0);
    chk("rst_rdata",  0, rdata,              32'd0);
    chk("rst_bus_oe", 0, {31'h0, bus_oe},    32'd0);
    chk("rst_ce_n",   0, {31'h0, sram_ce_n}, 32'd1);
    chk("rst_oe_n",   0, {31'h0, sram_oe_n}, 32'd1);
    chk("rst_we_n",   0, {31'h0, sram_we_n}, 32'd1);
    chk("rst_addr",   0, 32'(sram_addr),     32'd0);
    chk("rst_wdata",  0, {24'h0, sram_wdata}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i);
    end

    // Store side effects in the SRAM model
    chk("mem_sh_b0",   0, {24'h0, mem[19'h00040]}, 32'h0000_00CD);
    chk("mem_sh_b1",   0, {24'h0, mem[19'h00041]}, 32'h0000_00AB);
    chk("mem_sh_keep", 0, {24'h0, mem[19'h00042]}, 32'h0000_005A);
    chk("mem_sb_b0",   0, {24'h0, mem[19'h00050]}, 32'h0000_00E7);
    chk("mem_sb_keep", 0, {24'h0, mem[19'h00051]}, 32'h0000_003C);

    // Back-to-back: lw accepted in the DONE cycle of an lb
    @(negedge clk);
    wait_ready(100);
    req_read = 1'b1; req_size = 4'h8; addr = 32'h0000_0020;
    @(posedge clk);
    #1 req_read = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("b2b_lb_lat",   100, lat,   32'(BYTE_CYC + 1));
    chk("b2b_lb_rdata", 100, rdata, 32'hFFFFFF80);
    req_read = 1'b1; req_size = 4'h0; addr = 32'h0000_0100;
    @(posedge clk);
    #1 req_read = 1'b0;
    @(negedge clk);
    chk("b2b_setup_ce", 101, {31'h0, sram_ce_n}, 32'd0);
    chk("b2b_not_rdy",  101, {31'h0, ready},     32'd0);
    chk("b2b_addr",     101, 32'(sram_addr),     32'h0000_0100);
    lat = -1;
    if (done) lat = 1;
    for (int k = 2; k <= 100 && lat < 0; k++) begin
      @(negedge clk);
      if (done) lat = k;
    end
    chk("b2b_lw_lat",   101, lat,   32'(4 * BYTE_CYC + 1));
    chk("b2b_lw_rdata", 101, rdata, 32'hDEADBEEF);

    // Reset asserted while a word store is in ACCESS
    @(negedge clk);
    wait_ready(200);
    req_write = 1'b1; req_size = 4'h0; addr = 32'h0000_0070; wdata = 32'h11223344;
    @(posedge clk);
    #1 req_write = 1'b0;
    n = 0;
    while (sram_we_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_strobe", 200, {31'h0, sram_we_n}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_we_n",  200, {31'h0, sram_we_n}, 32'd1);
    chk("rst_mid_ce_n",  200, {31'h0, sram_ce_n}, 32'd1);
    chk("rst_mid_ready", 200, {31'h0, ready},     32'd1);
    chk("rst_mid_rdata", 200, rdata,              32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("rst_mid_nodone", 200, {31'h0, seen_done}, 32'd0);

    chk("strobe_rule", 300, viol, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
